// File: rtl/msrv32_load_store_unit.sv
// msrv32_load_store_unit: turns stage-3 load/store controls into req/ready data-bus cycles
// Ports:
//   clk_in, reset_in (async, active-high)
//   mem_rd_req_in/mem_wr_req_in, iadder_in, rs2_in, load_size_in, load_unsigned_in, rd_addr_in : stage-3 request
//   dmem_ready_in, dmem_rd_data_in : bus response
//   dmem_addr_out, dmem_wr_data_out, dmem_wr_mask_out, dmem_rd_req_out, dmem_wr_req_out : registered bus request
//   stall_out : hold upstream pipeline registers
//   load_data_out, load_rd_addr_out, load_valid_out : load writeback
//   misaligned_out, bus_timeout_out : one-cycle trap pulses
module msrv32_load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W = 8
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        mem_rd_req_in,
  input  logic        mem_wr_req_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] rs2_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic [4:0]  rd_addr_in,
  input  logic        dmem_ready_in,
  input  logic [31:0] dmem_rd_data_in,
  output logic [31:0] dmem_addr_out,
  output logic [31:0] dmem_wr_data_out,
  output logic [3:0]  dmem_wr_mask_out,
  output logic        dmem_rd_req_out,
  output logic        dmem_wr_req_out,
  output logic        stall_out,
  output logic [31:0] load_data_out,
  output logic [4:0]  load_rd_addr_out,
  output logic        load_valid_out,
  output logic        misaligned_out,
  output logic        bus_timeout_out
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES);
  localparam bit TO_EN = TIMEOUT_CYCLES != 0;
  state_t state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ldata_q, ldata_d;
  logic [3:0] mask_q, mask_d;
  logic [1:0] off_q, off_d, size_q, size_d;
  logic [4:0] rd_addr_q, rd_addr_d, lrd_q, lrd_d;
  logic uns_q, uns_d, rd_q, rd_d, wr_q, wr_d, lv_q, lv_d, mis_q, mis_d, to_q, to_d;
  logic req, mis, waiting, timeout;
  logic [31:0] sh, ext, st_data;
  logic [3:0] st_mask;
  assign req     = mem_rd_req_in | mem_wr_req_in;
  assign mis     = (load_size_in == 2'b01 & iadder_in[0]) | (load_size_in[1] & |iadder_in[1:0]);
  assign waiting = state_q != IDLE;
  assign timeout = TO_EN && cnt_q == TO_LIM && !dmem_ready_in;
  // Gated with reset so every output reads 0 while reset is held, even with a request pending.
  assign stall_out = !reset_in & ((!waiting & req & !mis) | (waiting & !dmem_ready_in & !timeout));
  assign sh  = dmem_rd_data_in >> {off_q, 3'b000};
  assign ext = size_q == 2'b00 ? {{24{!uns_q & sh[7]}}, sh[7:0]} :
               size_q == 2'b01 ? {{16{!uns_q & sh[15]}}, sh[15:0]} : sh;
  assign st_data = load_size_in == 2'b00 ? {4{rs2_in[7:0]}} :
                   load_size_in == 2'b01 ? {2{rs2_in[15:0]}} : rs2_in;
  assign st_mask = load_size_in == 2'b00 ? 4'b0001 << iadder_in[1:0] :
                   load_size_in == 2'b01 ? 4'b0011 << {iadder_in[1], 1'b0} : 4'b1111;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mask_d    = mask_q;
    off_d     = off_q;
    size_d    = size_q;
    uns_d     = uns_q;
    rd_addr_d = rd_addr_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    ldata_d   = ldata_q;
    lrd_d     = lrd_q;
    lv_d      = 1'b0;
    mis_d     = 1'b0;
    to_d      = 1'b0;
    if (!waiting) begin
      if (req && mis) begin
        mis_d = 1'b1;
      end else if (req) begin
        state_d   = mem_rd_req_in ? RD_WAIT : WR_WAIT;
        cnt_d     = '0;
        addr_d    = {iadder_in[31:2], 2'b00};
        off_d     = iadder_in[1:0];
        wdata_d   = st_data;
        mask_d    = st_mask;
        size_d    = load_size_in;
        uns_d     = load_unsigned_in;
        rd_addr_d = rd_addr_in;
        rd_d      = mem_rd_req_in;
        wr_d      = !mem_rd_req_in;
      end
    end else if (dmem_ready_in || timeout) begin
      state_d = IDLE;
      cnt_d   = '0;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      to_d    = !dmem_ready_in;
      lv_d    = dmem_ready_in && state_q == RD_WAIT;
      ldata_d = lv_d ? ext : ldata_q;
      lrd_d   = lv_d ? rd_addr_q : lrd_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
      off_q     <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      rd_addr_q <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      ldata_q   <= '0;
      lrd_q     <= '0;
      lv_q      <= 1'b0;
      mis_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mask_q    <= mask_d;
      off_q     <= off_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      rd_addr_q <= rd_addr_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      ldata_q   <= ldata_d;
      lrd_q     <= lrd_d;
      lv_q      <= lv_d;
      mis_q     <= mis_d;
      to_q      <= to_d;
    end
  end
  assign dmem_addr_out    = addr_q;
  assign dmem_wr_data_out = wdata_q;
  assign dmem_wr_mask_out = mask_q;
  assign dmem_rd_req_out  = rd_q;
  assign dmem_wr_req_out  = wr_q;
  assign load_data_out    = ldata_q;
  assign load_rd_addr_out = lrd_q;
  assign load_valid_out   = lv_q;
  assign misaligned_out   = mis_q;
  assign bus_timeout_out  = to_q;
endmodule

// File: tb/tb_msrv32_load_store_unit.sv
// tb_msrv32_load_store_unit: vector table plus timeout, wait-state and reset sequences
module tb_msrv32_load_store_unit;
  logic clk_in = 1'b0;
  logic reset_in = 1'b1;
  logic mem_rd_req_in = 1'b0, mem_wr_req_in = 1'b0, load_unsigned_in = 1'b0, dmem_ready_in = 1'b0;
  logic [31:0] iadder_in = '0, rs2_in = '0, dmem_rd_data_in = '0;
  logic [1:0] load_size_in = '0;
  logic [4:0] rd_addr_in = '0;
  logic [31:0] dmem_addr_out, dmem_wr_data_out, load_data_out;
  logic [3:0] dmem_wr_mask_out;
  logic dmem_rd_req_out, dmem_wr_req_out, stall_out, load_valid_out, misaligned_out, bus_timeout_out;
  logic [4:0] load_rd_addr_out;
  always #5 clk_in = ~clk_in;
  msrv32_load_store_unit #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .mem_rd_req_in(mem_rd_req_in), .mem_wr_req_in(mem_wr_req_in),
    .iadder_in(iadder_in), .rs2_in(rs2_in), .load_size_in(load_size_in),
    .load_unsigned_in(load_unsigned_in), .rd_addr_in(rd_addr_in),
    .dmem_ready_in(dmem_ready_in), .dmem_rd_data_in(dmem_rd_data_in),
    .dmem_addr_out(dmem_addr_out), .dmem_wr_data_out(dmem_wr_data_out),
    .dmem_wr_mask_out(dmem_wr_mask_out), .dmem_rd_req_out(dmem_rd_req_out),
    .dmem_wr_req_out(dmem_wr_req_out), .stall_out(stall_out),
    .load_data_out(load_data_out), .load_rd_addr_out(load_rd_addr_out),
    .load_valid_out(load_valid_out), .misaligned_out(misaligned_out),
    .bus_timeout_out(bus_timeout_out)
  );
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] rdata;
    logic [4:0]  rd_addr;
    logic        mis;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] ldata;
  } vec_t;
  vec_t v[12];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input vec_t t);
    mem_rd_req_in = t.rd;
    mem_wr_req_in = t.wr;
    iadder_in = t.addr;
    rs2_in = t.rs2;
    load_size_in = t.size;
    load_unsigned_in = t.uns;
    rd_addr_in = t.rd_addr;
  endtask
  task automatic drop();
    mem_rd_req_in = 1'b0;
    mem_wr_req_in = 1'b0;
    dmem_ready_in = 1'b0;
  endtask
  task automatic run(input vec_t t, input int waits);
    @(negedge clk_in);
    drive(t);
    #1;
    chk("stall_req_cycle", stall_out, t.mis ? 0 : 1);
    chk("no_req_yet", dmem_rd_req_out | dmem_wr_req_out, 0);
    if (t.mis) begin
      @(negedge clk_in);
      drop();
      #1;
      chk("misaligned_pulse", misaligned_out, 1);
      chk("mis_no_bus", dmem_rd_req_out | dmem_wr_req_out, 0);
      chk("mis_no_stall", stall_out, 0);
      @(negedge clk_in);
      #1;
      chk("misaligned_clear", misaligned_out, 0);
    end else begin
      for (int w = 0; w < waits; w++) begin
        @(negedge clk_in);
        dmem_ready_in = 1'b0;
        #1;
        chk("wait_stall", stall_out, 1);
        chk("wait_rd_req", dmem_rd_req_out, t.rd);
      end
      @(negedge clk_in);
      dmem_ready_in = 1'b1;
      dmem_rd_data_in = t.rdata;
      #1;
      chk("rd_req", dmem_rd_req_out, t.rd);
      chk("wr_req", dmem_wr_req_out, !t.rd);
      chk("bus_addr", dmem_addr_out, {t.addr[31:2], 2'b00});
      chk("ready_stall", stall_out, 0);
      if (!t.rd) begin
        chk("wr_data", dmem_wr_data_out, t.wdata);
        chk("wr_mask", dmem_wr_mask_out, t.mask);
      end
      @(negedge clk_in);
      drop();
      #1;
      chk("load_valid", load_valid_out, t.rd);
      chk("req_dropped", dmem_rd_req_out | dmem_wr_req_out, 0);
      if (t.rd) begin
        chk("load_data", load_data_out, t.ldata);
        chk("load_rd_addr", load_rd_addr_out, t.rd_addr);
      end
      @(negedge clk_in);
      #1;
      chk("valid_pulse_end", load_valid_out, 0);
    end
  endtask
  initial begin
    //       rd wr addr          rs2           sz    uns rdata         rd  mis wdata         mask     ldata
    v[0]  = '{1, 0, 32'h100, 32'h0,        2'd2, 0, 32'hDEADBEEF, 5, 0, 32'h0,        4'h0,    32'hDEADBEEF};
    v[1]  = '{1, 0, 32'h103, 32'h0,        2'd0, 0, 32'h80000000, 6, 0, 32'h0,        4'h0,    32'hFFFFFF80};
    v[2]  = '{1, 0, 32'h103, 32'h0,        2'd0, 1, 32'h80000000, 7, 0, 32'h0,        4'h0,    32'h00000080};
    v[3]  = '{1, 0, 32'h102, 32'h0,        2'd1, 0, 32'h80000000, 8, 0, 32'h0,        4'h0,    32'hFFFF8000};
    v[4]  = '{1, 0, 32'h100, 32'h0,        2'd1, 1, 32'h1234F00D, 9, 0, 32'h0,        4'h0,    32'h0000F00D};
    v[5]  = '{1, 0, 32'h101, 32'h0,        2'd0, 0, 32'h00007F00, 10, 0, 32'h0,       4'h0,    32'h0000007F};
    v[6]  = '{0, 1, 32'h101, 32'h000000AB, 2'd0, 0, 32'h0,        0, 0, 32'hABABABAB, 4'b0010, 32'h0};
    v[7]  = '{0, 1, 32'h102, 32'h00001234, 2'd1, 0, 32'h0,        0, 0, 32'h12341234, 4'b1100, 32'h0};
    v[8]  = '{0, 1, 32'h104, 32'hCAFEF00D, 2'd2, 0, 32'h0,        0, 0, 32'hCAFEF00D, 4'b1111, 32'h0};
    v[9]  = '{1, 0, 32'h102, 32'h0,        2'd2, 0, 32'h0,        3, 1, 32'h0,        4'h0,    32'h0};
    v[10] = '{0, 1, 32'h101, 32'h5555,     2'd1, 0, 32'h0,        0, 1, 32'h0,        4'h0,    32'h0};
    v[11] = '{1, 1, 32'h108, 32'h77,       2'd2, 0, 32'h0BADF00D, 11, 0, 32'h0,       4'h0,    32'h0BADF00D};
    mem_rd_req_in = 1'b1;
    repeat (2) @(negedge clk_in);
    #1;
    chk("reset_stall", stall_out, 0);
    chk("reset_reqs", {dmem_rd_req_out, dmem_wr_req_out, load_valid_out, misaligned_out, bus_timeout_out}, 0);
    chk("reset_addr", dmem_addr_out, 0);
    chk("reset_mask", dmem_wr_mask_out, 0);
    reset_in = 1'b0;
    drop();
    @(negedge clk_in);
    dmem_ready_in = 1'b1;
    @(negedge clk_in);
    dmem_ready_in = 1'b0;
    #1;
    chk("idle_ready_ignored", {dmem_rd_req_out, load_valid_out, stall_out}, 0);
    for (int i = 0; i < 12; i++) run(v[i], 0);
    run(v[3], 2);
    run(v[7], 1);
    // Timeout: counter reaches 4 on the fifth wait cycle
    @(negedge clk_in);
    drive(v[0]);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_in);
      #1;
      chk("to_wait_stall", stall_out, 1);
      chk("to_wait_req", dmem_rd_req_out, 1);
    end
    @(negedge clk_in);
    #1;
    chk("to_release_stall", stall_out, 0);
    chk("to_req_last", dmem_rd_req_out, 1);
    @(negedge clk_in);
    drop();
    #1;
    chk("to_pulse", bus_timeout_out, 1);
    chk("to_req_dropped", dmem_rd_req_out, 0);
    chk("to_no_valid", load_valid_out, 0);
    @(negedge clk_in);
    #1;
    chk("to_pulse_end", bus_timeout_out, 0);
    // Reset in the middle of RD_WAIT
    @(negedge clk_in);
    drive(v[1]);
    @(negedge clk_in);
    #1;
    chk("pre_reset_req", dmem_rd_req_out, 1);
    #1;
    reset_in = 1'b1;
    #1;
    chk("async_req_drop", dmem_rd_req_out, 0);
    chk("async_stall", stall_out, 0);
    chk("async_addr", dmem_addr_out, 0);
    @(negedge clk_in);
    reset_in = 1'b0;
    drop();
    @(negedge clk_in);
    #1;
    chk("post_reset_quiet", {load_valid_out, bus_timeout_out, dmem_rd_req_out}, 0);
    run(v[0], 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
